// File: rtl/perceptron_sum_sequencer_if.sv
// Start/term/sum handshake bundle plus the operand/result wires of the shared external adder.
// The sequencer connects through the slave modport; the surrounding datapath uses master.
interface perceptron_sum_sequencer_if #(
    parameter int W = 33
);
    logic         start_i;
    logic         clear_i;
    logic [W-1:0] bias_i;
    logic [W-1:0] term_i;
    logic         term_valid_i;
    logic         term_ready_o;
    logic [W-1:0] add_a_o;
    logic [W-1:0] add_b_o;
    logic [W-1:0] add_sum_i;
    logic [W-1:0] sum_o;
    logic         sum_valid_o;
    logic         sum_ready_i;
    logic         busy_o;
    logic         overflow_o;

    modport slave (
        input  start_i, clear_i, bias_i, term_i, term_valid_i, add_sum_i, sum_ready_i,
        output term_ready_o, add_a_o, add_b_o, sum_o, sum_valid_o, busy_o, overflow_o
    );

    modport master (
        output start_i, clear_i, bias_i, term_i, term_valid_i, add_sum_i, sum_ready_i,
        input  term_ready_o, add_a_o, add_b_o, sum_o, sum_valid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/perceptron_sum_sequencer.sv
// Sequences an external combinational adder to form bias + term[0] + ... + term[NUM_INPUTS-1].
// Define SUM_SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module perceptron_sum_sequencer #(
    parameter int SIGN       = 1,
    parameter int Q_M        = 16,
    parameter int Q_N        = 16,
    parameter int NUM_INPUTS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    perceptron_sum_sequencer_if.slave bus
);
    localparam int         W        = SIGN + Q_M + Q_N;
    localparam logic [7:0] LAST_IDX = 8'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_acc;
    logic [7:0]   r_count;
    logic         r_overflow;

    logic         w_term_ready;
    logic         w_sum_valid;
    logic         w_busy;
    logic         w_term_hs;
    logic         w_last_term;
    logic         w_overflow_det;
    logic [W-1:0] w_acc_next;

    assign w_term_hs      = bus.term_valid_i & w_term_ready;
    assign w_last_term    = (r_count == LAST_IDX);
    assign w_overflow_det = (r_acc[W-1] == bus.term_i[W-1]) &&
                            (bus.add_sum_i[W-1] != r_acc[W-1]);

`ifdef SUM_SATURATE_EN
    // Operand signs agree whenever overflow is flagged, so acc's sign picks the clamp direction.
    assign w_acc_next = !w_overflow_det ? bus.add_sum_i :
                        r_acc[W-1]      ? {1'b1, {(W-1){1'b0}}} :
                                          {1'b0, {(W-1){1'b1}}};
`else
    assign w_acc_next = bus.add_sum_i;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (bus.clear_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start_i)              w_state_next = S_ACCUM;
                S_ACCUM: if (w_term_hs && w_last_term) w_state_next = S_DONE;
                S_DONE:  if (bus.sum_ready_i)          w_state_next = S_IDLE;
                default:                               w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_term_ready = 1'b0;
        w_sum_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE:  w_busy       = 1'b0;
            S_ACCUM: w_term_ready = 1'b1;
            S_DONE:  w_sum_valid  = 1'b1;
            default: w_busy       = 1'b1;
        endcase
    end

    // clear_i abandons the sum but leaves acc untouched; start re-seeds it from bias.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_i) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_acc      <= bus.bias_i;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_term_hs) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 8'd1;
                        if (w_overflow_det) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.term_ready_o = w_term_ready;
    assign bus.sum_valid_o  = w_sum_valid;
    assign bus.busy_o       = w_busy;
    assign bus.add_a_o      = r_acc;
    assign bus.add_b_o      = bus.term_i;
    assign bus.sum_o        = r_acc;
    assign bus.overflow_o   = r_overflow;
endmodule

// File: tb/tb_perceptron_sum_sequencer.sv
// Bench for perceptron_sum_sequencer: scoreboard on the sum handshake of a 4-term instance,
// plus direct checks of per-term state, clear, asynchronous reset and a 1-term instance.
module tb_perceptron_sum_sequencer;
    localparam int W  = 33;
    localparam int N4 = 4;
    localparam longint MAX_POS = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MIN_NEG = -(longint'(1) <<< (W - 1));

    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t sum;
        logic  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    perceptron_sum_sequencer_if #(.W(W)) sif4 ();
    perceptron_sum_sequencer_if #(.W(W)) sif1 ();

    // The shared adder lives outside the sequencer.
    assign sif4.add_sum_i = sif4.add_a_o + sif4.add_b_o;
    assign sif1.add_sum_i = sif1.add_a_o + sif1.add_b_o;

    perceptron_sum_sequencer #(.NUM_INPUTS(N4)) u_dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (sif4)
    );

    perceptron_sum_sequencer #(.NUM_INPUTS(1)) u_dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (sif1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic word_t sw(input longint v);
        return W'(v);
    endfunction

    // Reference: exact signed sum, then range test decides overflow and wrap/clamp.
    task automatic model_add(inout word_t acc, inout logic ovf, input word_t term);
        longint s;
        s = longint'($signed(acc)) + longint'($signed(term));
        if (s > MAX_POS || s < MIN_NEG) begin
            ovf = 1'b1;
`ifdef SUM_SATURATE_EN
            s = (s > MAX_POS) ? MAX_POS : MIN_NEG;
`endif
        end
        acc = W'(s);
    endtask

    function automatic word_t rnd_word();
        word_t v;
        if ($urandom_range(0, 1) == 0) begin
            v = sw(longint'($urandom_range(0, 2000)) - 1000);
        end else begin
            v = {1'($urandom_range(0, 1)), 32'($urandom())};
        end
        return v;
    endfunction

    // Scoreboard monitor: every cycle a sum is presented it must match the head entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sif4.sum_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_bit("sb_unexpected_sum_valid", sif4.sum_valid_o, 1'b0);
            end else begin
                check("sb_sum", sif4.sum_o, sb_q[0].sum);
                check_bit("sb_overflow", sif4.overflow_o, sb_q[0].ovf);
                if (sif4.sum_ready_i) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_sum(input word_t bias, input word_t terms[N4], input int gap,
                           input int ready_wait, input bit poke);
        word_t acc_m[N4];
        logic  ovf_m[N4];
        word_t a;
        logic  o;
        a = bias;
        o = 1'b0;
        for (int i = 0; i < N4; i++) begin
            model_add(a, o, terms[i]);
            acc_m[i] = a;
            ovf_m[i] = o;
        end
        sb_q.push_back('{sum: a, ovf: o});

        sif4.start_i = 1'b1;
        sif4.bias_i  = bias;
        @(posedge clk); #1;
        sif4.start_i = 1'b0;
        sif4.bias_i  = sw(999);
        check_bit("busy_after_start", sif4.busy_o, 1'b1);

        for (int i = 0; i < N4; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    sif4.start_i = poke;
                    @(posedge clk); #1;
                    sif4.start_i = 1'b0;
                    check_bit("ready_during_bubble", sif4.term_ready_o, 1'b1);
                end
            end
            sif4.term_valid_i = 1'b1;
            sif4.term_i       = terms[i];
            #1;
            check("add_b_follows_term", sif4.add_b_o, terms[i]);
            check_bit("term_ready_in_accum", sif4.term_ready_o, 1'b1);
            @(posedge clk); #1;
            sif4.term_valid_i = 1'b0;
            sif4.term_i       = rnd_word();
            check("acc_after_term", sif4.add_a_o, acc_m[i]);
            check_bit("overflow_after_term", sif4.overflow_o, ovf_m[i]);
            check_bit("sum_valid_timing", sif4.sum_valid_o, (i == N4 - 1));
        end

        repeat (ready_wait) begin
            sif4.start_i = poke;
            @(posedge clk); #1;
            sif4.start_i = 1'b0;
            check_bit("held_in_done", sif4.sum_valid_o, 1'b1);
        end
        sif4.sum_ready_i = 1'b1;
        sif4.start_i     = poke;
        @(posedge clk); #1;
        sif4.sum_ready_i = 1'b0;
        sif4.start_i     = 1'b0;
        check_bit("idle_busy_after_sum", sif4.busy_o, 1'b0);
        check_bit("idle_valid_after_sum", sif4.sum_valid_o, 1'b0);
    endtask

    task automatic run_clear();
        word_t a;
        logic  o;
        a = sw(MAX_POS);
        o = 1'b0;
        sif4.start_i = 1'b1;
        sif4.bias_i  = a;
        @(posedge clk); #1;
        sif4.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sif4.term_valid_i = 1'b1;
            sif4.term_i       = sw(1);
            model_add(a, o, sw(1));
            @(posedge clk); #1;
            sif4.term_valid_i = 1'b0;
        end
        check_bit("clear_pre_overflow", sif4.overflow_o, o);
        sif4.clear_i      = 1'b1;
        sif4.term_valid_i = 1'b1;
        sif4.term_i       = sw(5);
        @(posedge clk); #1;
        sif4.clear_i      = 1'b0;
        sif4.term_valid_i = 1'b0;
        check_bit("clear_busy", sif4.busy_o, 1'b0);
        check_bit("clear_term_ready", sif4.term_ready_o, 1'b0);
        check_bit("clear_overflow", sif4.overflow_o, 1'b0);
        check_bit("clear_sum_valid", sif4.sum_valid_o, 1'b0);
        check("clear_keeps_acc", sif4.sum_o, a);
    endtask

    task automatic run_single(input word_t bias, input word_t term);
        word_t a;
        logic  o;
        a = bias;
        o = 1'b0;
        model_add(a, o, term);
        sif1.start_i = 1'b1;
        sif1.bias_i  = bias;
        @(posedge clk); #1;
        sif1.start_i = 1'b0;
        check_bit("n1_term_ready", sif1.term_ready_o, 1'b1);
        check_bit("n1_no_early_valid", sif1.sum_valid_o, 1'b0);
        sif1.term_valid_i = 1'b1;
        sif1.term_i       = term;
        @(posedge clk); #1;
        sif1.term_valid_i = 1'b0;
        check_bit("n1_sum_valid", sif1.sum_valid_o, 1'b1);
        check_bit("n1_ready_dropped", sif1.term_ready_o, 1'b0);
        check("n1_sum", sif1.sum_o, a);
        check_bit("n1_overflow", sif1.overflow_o, o);
        sif1.sum_ready_i = 1'b1;
        @(posedge clk); #1;
        sif1.sum_ready_i = 1'b0;
        check_bit("n1_idle", sif1.busy_o, 1'b0);
    endtask

    task automatic run_reset();
        word_t tv[N4];
        word_t a;
        logic  o;
        a = sw(32'h0001_2345);
        o = 1'b0;
        for (int i = 0; i < N4; i++) begin
            tv[i] = rnd_word();
            model_add(a, o, tv[i]);
        end
        sb_q.push_back('{sum: a, ovf: o});
        sif4.start_i = 1'b1;
        sif4.bias_i  = sw(32'h0001_2345);
        @(posedge clk); #1;
        sif4.start_i = 1'b0;
        for (int i = 0; i < N4; i++) begin
            sif4.term_valid_i = 1'b1;
            sif4.term_i       = tv[i];
            @(posedge clk); #1;
        end
        sif4.term_valid_i = 1'b0;
        check_bit("reset_pre_valid", sif4.sum_valid_o, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        check_bit("async_reset_valid", sif4.sum_valid_o, 1'b0);
        check_bit("async_reset_busy", sif4.busy_o, 1'b0);
        check_bit("async_reset_ready", sif4.term_ready_o, 1'b0);
        check_bit("async_reset_overflow", sif4.overflow_o, 1'b0);
        check("async_reset_sum", sif4.sum_o, '0);
        check("async_reset_add_a", sif4.add_a_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t tv[N4];
        sif4.start_i = 1'b0; sif4.clear_i = 1'b0; sif4.bias_i = '0; sif4.term_i = '0;
        sif4.term_valid_i = 1'b0; sif4.sum_ready_i = 1'b0;
        sif1.start_i = 1'b0; sif1.clear_i = 1'b0; sif1.bias_i = '0; sif1.term_i = '0;
        sif1.term_valid_i = 1'b0; sif1.sum_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_busy", sif4.busy_o, 1'b0);
        check_bit("rst_term_ready", sif4.term_ready_o, 1'b0);
        check_bit("rst_sum_valid", sif4.sum_valid_o, 1'b0);
        check_bit("rst_overflow", sif4.overflow_o, 1'b0);
        check("rst_sum", sif4.sum_o, '0);
        check("rst_add_a", sif4.add_a_o, '0);
        check_bit("rst_n1_busy", sif1.busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cancelling terms back-to-back.
        tv = '{sw(123), sw(146), sw(-123), sw(-146)};
        run_sum(sw(10), tv, 0, 0, 1'b0);
        // Bubbles between terms and consumer back-pressure.
        tv = '{sw(100), sw(-300), sw(0), sw(0)};
        run_sum(sw(0), tv, 2, 3, 1'b0);
        // Start pulses in ACCUM and DONE are ignored; the next start picks up its own bias.
        tv = '{sw(1), sw(2), sw(3), sw(4)};
        run_sum(sw(-50), tv, 1, 1, 1'b1);
        tv = '{sw(-7), sw(8), sw(9), sw(-10)};
        run_sum(sw(77), tv, 0, 0, 1'b0);
        // Near full scale: in-range for this width, then genuinely overflowing.
        tv = '{sw(32'h0002_0000), sw(1), sw(1), sw(1)};
        run_sum(sw(32'h7FFF_0000), tv, 0, 0, 1'b0);
        run_sum(sw(33'h0_FFFF_0000), tv, 0, 1, 1'b0);
        tv = '{sw(-(longint'(1) <<< 31)), sw(-(longint'(1) <<< 31)), sw(-1), sw(5)};
        run_sum(sw(MIN_NEG + 10), tv, 0, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N4; i++) begin
                tv[i] = rnd_word();
            end
            run_sum(rnd_word(), tv, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        run_clear();

        run_single(sw(MIN_NEG), sw(-1));
        run_single(sw(5), sw(7));
        run_single(sw(MAX_POS), sw(1));
        run_single(rnd_word(), rnd_word());

        run_reset();
        tv = '{sw(11), sw(22), sw(33), sw(44)};
        run_sum(sw(1), tv, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", word_t'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
